ddr_cmd_encoder: RTL and testbench



---
 rtl/ddr_cmd_encoder.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ddr_cmd_encoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_encoder.sv
// DDR4 command encoder: request FIFO, strobe arbitration, registered C/A pins, MR capture.
// Optional macro CMD_PARITY_EN enables registered even C/A parity; otherwise par is tied 0.
module ddr_cmd_encoder #(
  parameter int LOG_ADDR_W = 40,
  parameter int BG_W       = 2,
  parameter int BA_W       = 2,
  parameter int ROW_W      = 18,
  parameter int COL_W      = 10,
  parameter int RANKS      = 1,
  parameter int QDEPTH     = 8
) (
  input  logic                      CK_t,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_type,
  input  logic [LOG_ADDR_W-1:0]     req_addr,
  input  logic                      act_rdy,
  input  logic                      cas_rdy,
  input  logic                      pre_rdy,
  input  logic                      prea_rdy,
  input  logic                      ref_rdy,
  input  logic                      mrs_rdy,
  input  logic                      zqcl_rdy,
  input  logic [17:0]               mode_reg,
  output logic [RANKS-1:0]          cs_n,
  output logic                      act_n,
  output logic                      ras_n_a16,
  output logic                      cas_n_a15,
  output logic                      we_n_a14,
  output logic                      a17,
  output logic                      a13,
  output logic                      a12_bc_n,
  output logic                      a11,
  output logic                      a10_ap,
  output logic [BG_W-1:0]           bg,
  output logic [BA_W-1:0]           ba,
  output logic [9:0]                a9_a0,
  output logic                      par,
  output logic [3:0]                cmd_code,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      head_open,
  output logic                      seq_err,
  output logic [4:0]                cl,
  output logic [4:0]                al,
  output logic [4:0]                cwl,
  output logic [4:0]                tccd,
  output logic [3:0]                bl
);

  localparam int RK_W   = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int RK_LSB = BG_W + BA_W + ROW_W + COL_W;

  typedef enum logic [3:0] {
    C_DES = 4'd0, C_ACT = 4'd1, C_RD = 4'd2, C_WR = 4'd3, C_RDA = 4'd4, C_WRA = 4'd5,
    C_PRE = 4'd6, C_PREA = 4'd7, C_REF = 4'd8, C_MRS = 4'd9, C_ZQCL = 4'd10
  } cmd_e;

  typedef struct packed {
    logic [RK_W-1:0]  rank;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [1:0]       typ;
  } req_t;

  // a[16:14] double as ras/cas/we when act_n=1
  typedef struct packed {
    logic [RANKS-1:0] cs_n;
    logic             act_n;
    logic [17:0]      a;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
  } pins_t;

  function automatic logic [RANKS-1:0] rank_cs(input logic [RK_W-1:0] r);
    return ~(RANKS'(1) << r);
  endfunction

  // reset asserts immediately, releases on the second CK_t edge
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge CK_t or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];

  req_t dec;
  always_comb begin
    dec      = '0;
    dec.bg   = req_addr[BG_W-1:0];
    dec.ba   = req_addr[BG_W +: BA_W];
    dec.row  = req_addr[BG_W+BA_W +: ROW_W];
    dec.col  = req_addr[BG_W+BA_W+ROW_W +: COL_W];
    dec.typ  = req_type;
    if (RANKS > 1) dec.rank = req_addr[RK_LSB +: RK_W];
  end

  req_t             mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             push, pop, empty, open_q, open_set;
  req_t             head;

  assign req_ready = (count < (PTR_W+1)'(QDEPTH));
  assign push      = req_valid && req_ready;
  assign empty     = (count == '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge CK_t)
    if (push) mem[wr_ptr] <= dec;

  always_ff @(posedge CK_t or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      open_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
      if (pop)           open_q <= 1'b0;
      else if (open_set) open_q <= 1'b1;
    end

  cmd_e  cmd;
  pins_t p;
  logic  err, par_nxt;

  always_comb begin
    cmd      = C_DES;
    err      = 1'b0;
    pop      = 1'b0;
    open_set = 1'b0;
    p        = '1;
    if (mrs_rdy) begin
      cmd      = C_MRS;
      p.cs_n   = '0;
      p.a      = {4'b0000, mode_reg[13:0]};
      p.bg     = '0;
      p.bg[0]  = mode_reg[17];
      p.ba     = BA_W'(mode_reg[16:15]);
    end else if (ref_rdy) begin
      cmd        = C_REF;
      p.cs_n     = '0;
      p.a[16:14] = 3'b001;
    end else if (zqcl_rdy) begin
      cmd        = C_ZQCL;
      p.cs_n     = '0;
      p.a[16:14] = 3'b110;
      p.a[10]    = 1'b1;
    end else if (prea_rdy) begin
      cmd        = C_PREA;
      p.cs_n     = '0;
      p.a[16:14] = 3'b010;
      p.a[10]    = 1'b1;
    end else if (pre_rdy) begin
      cmd        = C_PRE;
      p.a[16:14] = 3'b010;
      p.a[10]    = 1'b0;
      if (empty) p.cs_n = rank_cs('0);
      else begin
        p.cs_n = rank_cs(head.rank);
        p.bg   = head.bg;
        p.ba   = head.ba;
      end
    end else if (cas_rdy) begin
      if (empty || !open_q) err = 1'b1;
      else begin
        cmd        = cmd_e'(4'd2 + {2'b00, head.typ});
        pop        = 1'b1;
        p.cs_n     = rank_cs(head.rank);
        p.bg       = head.bg;
        p.ba       = head.ba;
        p.a[16:14] = {2'b10, ~head.typ[0]};
        p.a[10]    = head.typ[1];
        p.a[9:0]   = 10'(head.col);
      end
    end else if (act_rdy) begin
      if (empty || open_q) err = 1'b1;
      else begin
        cmd      = C_ACT;
        open_set = 1'b1;
        p.cs_n   = rank_cs(head.rank);
        p.act_n  = 1'b0;
        p.a      = 18'(head.row);
        p.bg     = head.bg;
        p.ba     = head.ba;
      end
    end
`ifdef CMD_PARITY_EN
    par_nxt = (cmd == C_DES) ? 1'b0 : ^{p.act_n, p.a, p.bg, p.ba};
`else
    par_nxt = 1'b0;
`endif
  end

  pins_t pins_q;
  cmd_e  cmd_q;
  logic  err_q, par_q;

  always_ff @(posedge CK_t or negedge rst_n)
    if (!rst_n) begin
      pins_q <= '1;
      cmd_q  <= C_DES;
      err_q  <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      pins_q <= p;
      cmd_q  <= cmd;
      err_q  <= err;
      par_q  <= par_nxt;
    end

  // MR payload is latched with the MRS pins and decoded one cycle later
  logic        mrs_vld;
  logic [17:0] mrs_val;

  always_ff @(posedge CK_t or negedge rst_n)
    if (!rst_n) begin
      mrs_vld <= 1'b0;
      mrs_val <= '0;
      cl      <= 5'd9;
      bl      <= 4'd8;
      al      <= 5'd0;
      cwl     <= 5'd9;
      tccd    <= 5'd4;
    end else begin
      mrs_vld <= (cmd == C_MRS);
      if (cmd == C_MRS) mrs_val <= mode_reg;
      if (mrs_vld) begin
        case (mrs_val[17:15])
          3'd0: begin
            cl <= (mrs_val[6:3] < 4'd4) ? 5'd9 + 5'(mrs_val[6:3]) : 5'd9;
            bl <= (mrs_val[1:0] == 2'b10) ? 4'd4 : 4'd8;
          end
          3'd1: al   <= (mrs_val[4:3] == 2'd1 || mrs_val[4:3] == 2'd2) ?
                        cl - 5'(mrs_val[4:3]) : 5'd0;
          3'd2: cwl  <= (mrs_val[5:3] == 3'd0 || mrs_val[5:3] == 3'd2) ?
                        5'd9 + 5'(mrs_val[5:3]) : 5'd9;
          3'd6: tccd <= 5'd4 + 5'(mrs_val[12:10]);
          default: ;
        endcase
      end
    end

  assign cs_n      = pins_q.cs_n;
  assign act_n     = pins_q.act_n;
  assign a17       = pins_q.a[17];
  assign ras_n_a16 = pins_q.a[16];
  assign cas_n_a15 = pins_q.a[15];
  assign we_n_a14  = pins_q.a[14];
  assign a13       = pins_q.a[13];
  assign a12_bc_n  = pins_q.a[12];
  assign a11       = pins_q.a[11];
  assign a10_ap    = pins_q.a[10];
  assign a9_a0     = pins_q.a[9:0];
  assign bg        = pins_q.bg;
  assign ba        = pins_q.ba;
  assign par       = par_q;
  assign cmd_code  = cmd_q;
  assign seq_err   = err_q;
  assign q_count   = count;
  assign head_open = open_q;

  logic unused_ok;
  assign unused_ok = ^{req_addr, mode_reg, mrs_val};

endmodule

// File: tb/tb_ddr_cmd_encoder.sv
// Bench for ddr_cmd_encoder (RANKS=4): directed vector table, hand-written corner sequences
// and a random run, all checked against a queue-based command model.
module tb_ddr_cmd_encoder;
  localparam int RANKS  = 4;
  localparam int QDEPTH = 8;

  logic        CK_t, reset_n, req_valid, req_ready;
  logic [1:0]  req_type;
  logic [39:0] req_addr;
  logic        act_rdy, cas_rdy, pre_rdy, prea_rdy, ref_rdy, mrs_rdy, zqcl_rdy;
  logic [17:0] mode_reg;
  logic [3:0]  cs_n;
  logic        act_n, ras_n_a16, cas_n_a15, we_n_a14, a17, a13, a12_bc_n, a11, a10_ap;
  logic [1:0]  bg, ba;
  logic [9:0]  a9_a0;
  logic        par, head_open, seq_err;
  logic [3:0]  cmd_code, bl;
  logic [3:0]  q_count;
  logic [4:0]  cl, al, cwl, tccd;

  ddr_cmd_encoder #(.RANKS(RANKS), .QDEPTH(QDEPTH)) dut (
    .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .act_rdy(act_rdy), .cas_rdy(cas_rdy),
    .pre_rdy(pre_rdy), .prea_rdy(prea_rdy), .ref_rdy(ref_rdy), .mrs_rdy(mrs_rdy),
    .zqcl_rdy(zqcl_rdy), .mode_reg(mode_reg), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14), .a17(a17),
    .a13(a13), .a12_bc_n(a12_bc_n), .a11(a11), .a10_ap(a10_ap), .bg(bg), .ba(ba),
    .a9_a0(a9_a0), .par(par), .cmd_code(cmd_code), .q_count(q_count),
    .head_open(head_open), .seq_err(seq_err), .cl(cl), .al(al), .cwl(cwl),
    .tccd(tccd), .bl(bl)
  );

  initial CK_t = 1'b0;
  always #5 CK_t = ~CK_t;

  typedef struct {
    logic [1:0]  rank, bg, ba, typ;
    logic [17:0] row;
    logic [9:0]  col;
  } ent_t;

  typedef struct {
    bit          v;
    logic [1:0]  t;
    logic [39:0] ad;
    logic [6:0]  s;   // {mrs,ref,zq,prea,pre,cas,act}
    logic [17:0] mr;
    int          e_cmd;
    int          e_q;
    bit          e_err;
  } vec_t;

  ent_t        q[$];
  bit          m_open, pend;
  logic [17:0] pend_mr;
  int          m_cl, m_bl, m_al, m_cwl, m_tccd;
  int          errors, checks;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic ent_t decode(input logic [39:0] ad, input logic [1:0] t);
    ent_t e;
    longint unsigned a = 64'(ad);
    e.bg   = 2'(a % 4);
    e.ba   = 2'((a / 4) % 4);
    e.row  = 18'((a / 16) % (64'd1 << 18));
    e.col  = 10'((a / (64'd1 << 22)) % 1024);
    e.rank = 2'((a / (64'd1 << 32)) % 4);
    e.typ  = t;
    return e;
  endfunction

  // {cs_n[4], act_n, A17..A0, bg[2], ba[2]}
  function automatic logic [26:0] exp_pins(input int cmd, input ent_t e, input bit have,
                                           input logic [17:0] mr);
    logic [3:0]  cs = 4'hF;
    logic        act = 1'b1;
    logic [17:0] a = '1;
    logic [1:0]  b_g = 2'b11, b_a = 2'b11;
    logic [3:0]  rsel = 4'hF & ~(4'd1 << e.rank);
    case (cmd)
      1: begin cs = rsel; act = 1'b0; a = e.row; b_g = e.bg; b_a = e.ba; end
      2, 3, 4, 5: begin
        cs = rsel; b_g = e.bg; b_a = e.ba;
        a[16:14] = {2'b10, (cmd == 3 || cmd == 5) ? 1'b0 : 1'b1};
        a[10] = (cmd >= 4);
        a[9:0] = e.col;
      end
      6: begin
        a[16:14] = 3'b010; a[10] = 1'b0;
        if (have) begin cs = rsel; b_g = e.bg; b_a = e.ba; end
        else cs = 4'b1110;
      end
      7: begin cs = 4'h0; a[16:14] = 3'b010; a[10] = 1'b1; end
      8: begin cs = 4'h0; a[16:14] = 3'b001; end
      9: begin cs = 4'h0; a = {4'b0000, mr[13:0]}; b_g = {1'b0, mr[17]}; b_a = mr[16:15]; end
      10: begin cs = 4'h0; a[16:14] = 3'b110; a[10] = 1'b1; end
      default: ;
    endcase
    return {cs, act, a, b_g, b_a};
  endfunction

  task automatic apply_mr(input logic [17:0] mr);
    int f;
    case (mr[17:15])
      3'd0: begin
        f = int'(mr[6:3]);
        m_cl = (f < 4) ? 9 + f : 9;
        m_bl = (mr[1:0] == 2'b10) ? 4 : 8;
      end
      3'd1: begin f = int'(mr[4:3]); m_al = (f == 1 || f == 2) ? m_cl - f : 0; end
      3'd2: begin f = int'(mr[5:3]); m_cwl = (f == 0 || f == 2) ? 9 + f : 9; end
      3'd6: m_tccd = 4 + int'(mr[12:10]);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    q.delete();
    m_open = 0; pend = 0; pend_mr = '0;
    m_cl = 9; m_bl = 8; m_al = 0; m_cwl = 9; m_tccd = 4;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_type = 0; req_addr = '0; mode_reg = '0;
    {mrs_rdy, ref_rdy, zqcl_rdy, prea_rdy, pre_rdy, cas_rdy, act_rdy} = 7'h00;
  endtask

  // Called just after a rising edge; drives one cycle of inputs and checks the result.
  task automatic step(input bit v, input logic [1:0] t, input logic [39:0] ad,
                      input logic [6:0] s, input logic [17:0] mr);
    int          cmd = 0;
    bit          err = 0, pop = 0, opn = 0, full, push, have;
    ent_t        h, ne;
    logic [26:0] ep;
    logic        epar;
    req_valid = v; req_type = t; req_addr = ad; mode_reg = mr;
    {mrs_rdy, ref_rdy, zqcl_rdy, prea_rdy, pre_rdy, cas_rdy, act_rdy} = s;
    full = (q.size() >= QDEPTH);
    push = v && !full;
    have = (q.size() > 0);
    h = have ? q[0] : decode('0, 2'b00);
    ne = decode(ad, t);
    if (s[6]) cmd = 9;
    else if (s[5]) cmd = 8;
    else if (s[4]) cmd = 10;
    else if (s[3]) cmd = 7;
    else if (s[2]) cmd = 6;
    else if (s[1]) begin
      if (!have || !m_open) err = 1;
      else begin cmd = 2 + int'(h.typ); pop = 1; end
    end else if (s[0]) begin
      if (!have || m_open) err = 1;
      else begin cmd = 1; opn = 1; end
    end
    ep = exp_pins(cmd, h, have, mr);
`ifdef CMD_PARITY_EN
    epar = (cmd == 0) ? 1'b0 : ^ep[22:0];
`else
    epar = 1'b0;
`endif
    #1;
    chk("req_ready", req_ready, !full);
    @(posedge CK_t); #1;
    if (pend) apply_mr(pend_mr);
    pend = (cmd == 9); pend_mr = mr;
    if (pop) begin void'(q.pop_front()); m_open = 0; end
    if (opn) m_open = 1;
    if (push) q.push_back(ne);
    chk("cmd_code", cmd_code, cmd);
    chk("pins", {cs_n, act_n, a17, ras_n_a16, cas_n_a15, we_n_a14, a13, a12_bc_n, a11,
                 a10_ap, a9_a0, bg, ba}, ep);
    chk("par", par, epar);
    chk("seq_err", seq_err, err);
    chk("q_count", q_count, q.size());
    chk("head_open", head_open, m_open);
    chk("mr_params", {cl, al, cwl, tccd, bl}, {5'(m_cl), 5'(m_al), 5'(m_cwl), 5'(m_tccd), 4'(m_bl)});
  endtask

  task automatic pulse_reset_release();
    @(negedge CK_t) reset_n = 1'b1;
    repeat (3) @(posedge CK_t);
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    logic [39:0] ad;
    logic [17:0] mr;
    logic [6:0]  s;
    tbl[0]  = '{1, 2'd1, 40'h00_0123_4567, 7'h00, 18'h0,     0, 1, 0};
    tbl[1]  = '{0, 2'd0, 40'h0,            7'h01, 18'h0,     1, 1, 0};
    tbl[2]  = '{0, 2'd0, 40'h0,            7'h02, 18'h0,     3, 0, 0};
    tbl[3]  = '{0, 2'd0, 40'h0,            7'h02, 18'h0,     0, 0, 1};
    tbl[4]  = '{0, 2'd0, 40'h0,            7'h00, 18'h0,     0, 0, 0};
    tbl[5]  = '{1, 2'd0, 40'h02_8000_1234, 7'h00, 18'h0,     0, 1, 0};
    tbl[6]  = '{0, 2'd0, 40'h0,            7'h25, 18'h0,     8, 1, 0};
    tbl[7]  = '{0, 2'd0, 40'h0,            7'h01, 18'h0,     1, 1, 0};
    tbl[8]  = '{0, 2'd0, 40'h0,            7'h01, 18'h0,     0, 1, 1};
    tbl[9]  = '{0, 2'd0, 40'h0,            7'h08, 18'h0,     7, 1, 0};
    tbl[10] = '{0, 2'd0, 40'h0,            7'h02, 18'h0,     2, 0, 0};
    tbl[11] = '{0, 2'd0, 40'h0,            7'h40, 18'h0000A, 9, 0, 0};
    tbl[12] = '{0, 2'd0, 40'h0,            7'h40, 18'h08010, 9, 0, 0};
    tbl[13] = '{0, 2'd0, 40'h0,            7'h10, 18'h0,    10, 0, 0};
    tbl[14] = '{0, 2'd0, 40'h0,            7'h04, 18'h0,     6, 0, 0};
    tbl[15] = '{1, 2'd2, 40'h01_0000_0FF0, 7'h02, 18'h0,     0, 1, 1};
    tbl[16] = '{0, 2'd0, 40'h0,            7'h01, 18'h0,     1, 1, 0};
    tbl[17] = '{0, 2'd0, 40'h0,            7'h04, 18'h0,     6, 1, 0};
    tbl[18] = '{1, 2'd3, 40'h03_1234_5678, 7'h02, 18'h0,     4, 1, 0};
    tbl[19] = '{0, 2'd0, 40'h0,            7'h01, 18'h0,     1, 1, 0};
    tbl[20] = '{0, 2'd0, 40'h0,            7'h02, 18'h0,     5, 0, 0};

    errors = 0; checks = 0;
    model_reset();
    idle_inputs();
    reset_n = 1'b0;
    #12;
    chk("rst_pins", {cs_n, act_n, a17, ras_n_a16, cas_n_a15, we_n_a14, a13, a12_bc_n, a11,
                     a10_ap, a9_a0, bg, ba}, 27'h7FF_FFFF);
    chk("rst_cmd", cmd_code, 0);
    chk("rst_par_err", {par, seq_err, head_open}, 3'b000);
    chk("rst_q", q_count, 0);
    chk("rst_params", {cl, al, cwl, tccd, bl}, {5'd9, 5'd0, 5'd9, 5'd4, 4'd8});
    pulse_reset_release();

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].t, tbl[i].ad, tbl[i].s, tbl[i].mr);
      chk("tbl_cmd", cmd_code, tbl[i].e_cmd);
      chk("tbl_q", q_count, tbl[i].e_q);
      chk("tbl_err", seq_err, tbl[i].e_err);
      if (i == 1) chk("act_wr_bg_ba", {bg, ba}, 4'b1101);
      if (i == 2) chk("wr_we_a10", {we_n_a14, a10_ap}, 2'b00);
      if (i == 7) chk("act_cs_rank2", cs_n, 4'b1011);
      if (i == 9) chk("prea_cs", cs_n, 4'b0000);
    end
    step(0, 0, '0, 7'h00, '0);
    chk("mr0_cl", cl, 10);
    chk("mr0_bl", bl, 4);
    chk("mr1_al", al, 8);

    // full FIFO: a held ninth request is not taken in the pop cycle
    for (int i = 0; i < QDEPTH; i++)
      step(1, 2'($urandom), {$urandom, $urandom}, 7'h00, '0);
    chk("full_ready", req_ready, 0);
    chk("full_q", q_count, 8);
    ad = 40'h00_00AB_CDEF;
    step(1, 2'd1, ad, 7'h01, '0);
    step(1, 2'd1, ad, 7'h02, '0);
    chk("full_pop_no_push", q_count, 7);
    step(1, 2'd1, ad, 7'h00, '0);
    chk("refill", q_count, 8);
    for (int i = 0; i < QDEPTH; i++) begin
      step(0, 0, '0, 7'h01, '0);
      step(0, 0, '0, 7'h02, '0);
    end

    // asynchronous reset with entries queued and an ACT on the pins
    for (int i = 0; i < 3; i++) step(1, 2'($urandom), {$urandom, $urandom}, 7'h00, '0);
    step(0, 0, '0, 7'h01, '0);
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_q", q_count, 0);
    chk("arst_cmd", cmd_code, 0);
    chk("arst_pins", {cs_n, act_n, ras_n_a16, cas_n_a15, we_n_a14}, 8'hFF);
    chk("arst_open", head_open, 0);
    model_reset();
    pulse_reset_release();

    for (int n = 0; n < 600; n++) begin
      s = 7'h00;
      if ($urandom_range(0, 2) == 0) s[0] = 1'b1;
      if ($urandom_range(0, 2) == 0) s[1] = 1'b1;
      if ($urandom_range(0, 7) == 0) s[2] = 1'b1;
      if ($urandom_range(0, 15) == 0) s[3] = 1'b1;
      if ($urandom_range(0, 15) == 0) s[4] = 1'b1;
      if ($urandom_range(0, 15) == 0) s[5] = 1'b1;
      if ($urandom_range(0, 11) == 0) s[6] = 1'b1;
      mr = 18'($urandom);
      case ($urandom_range(0, 4))
        0: mr[17:15] = 3'd0;
        1: mr[17:15] = 3'd1;
        2: mr[17:15] = 3'd2;
        3: mr[17:15] = 3'd6;
        default: ;
      endcase
      step($urandom_range(0, 2) == 0, 2'($urandom), {$urandom, $urandom}, s, mr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
